// File: rtl/avrisc621_mc_pkg.sv
// Shared definitions for the multi-core result path: slave ids, word layout,
// arbiter state encoding and a one-hot helper for acknowledge generation.
package avrisc621_mc_pkg;

    localparam int NUM_SLAVES = 3;
    localparam int DATA_W     = 8;
    localparam int ID_W       = 2;
    localparam int SLV_W      = DATA_W + ID_W;
    localparam int ID_LSB     = DATA_W;
    localparam int ID_MSB     = DATA_W + ID_W - 1;

    localparam logic [ID_W-1:0] SLV0 = 2'd0;
    localparam logic [ID_W-1:0] SLV1 = 2'd1;
    localparam logic [ID_W-1:0] SLV2 = 2'd2;

    // Starting with the pointer on slave 2 gives slave 0 first priority.
    localparam logic [ID_W-1:0] RR_RESET_LAST = SLV2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        DRAIN   = 2'd2
    } arb_state_t;

    function automatic logic [NUM_SLAVES-1:0] slave_onehot(input logic [ID_W-1:0] id);
        logic [NUM_SLAVES-1:0] result;
        result = '0;
        case (id)
            SLV0:    result = 3'b001;
            SLV1:    result = 3'b010;
            SLV2:    result = 3'b100;
            default: result = 3'b000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/av_rr_pick3.sv
// Combinational 3-way round-robin picker: searches last+1, last+2, last+3 (mod 3)
// and reports the first requesting slave.
module av_rr_pick3
    import avrisc621_mc_pkg::*;
(
    input  logic [NUM_SLAVES-1:0] req,
    input  logic [ID_W-1:0]       last,
    output logic [ID_W-1:0]       gnt_id,
    output logic                  any
);

    always_comb begin
        gnt_id = SLV0;
        any    = |req;
        case (last)
            SLV0: begin
                if (req[1])      gnt_id = SLV1;
                else if (req[2]) gnt_id = SLV2;
                else if (req[0]) gnt_id = SLV0;
            end
            SLV1: begin
                if (req[2])      gnt_id = SLV2;
                else if (req[0]) gnt_id = SLV0;
                else if (req[1]) gnt_id = SLV1;
            end
            default: begin
                if (req[0])      gnt_id = SLV0;
                else if (req[1]) gnt_id = SLV1;
                else if (req[2]) gnt_id = SLV2;
            end
        endcase
    end

endmodule

// File: rtl/av_slave_result_arbiter.sv
// Round-robin 4-phase result arbiter from three slave cores to the master core.
// Optional embedded-id checking is enabled by defining AV_ARB_ID_CHECK_EN.
module av_slave_result_arbiter
    import avrisc621_mc_pkg::*;
(
    input  logic                  Clock_pin,
    input  logic                  Reset_pin,
    input  logic [NUM_SLAVES-1:0] S_M_req,
    input  logic [SLV_W-1:0]      Slave0_out,
    input  logic [SLV_W-1:0]      Slave1_out,
    input  logic [SLV_W-1:0]      Slave2_out,
    output logic [NUM_SLAVES-1:0] S_ack,
    output logic                  M_valid,
    output logic [DATA_W-1:0]     M_data,
    output logic [ID_W-1:0]       M_slave_id,
    input  logic                  M_ack,
    output logic [7:0]            Id_err_cnt
);

    arb_state_t            state, next_state;
    logic [ID_W-1:0]       last, next_last;
    logic [ID_W-1:0]       gnt, next_gnt;
    logic                  m_valid, next_valid;
    logic [DATA_W-1:0]     m_data, next_data;
    logic [ID_W-1:0]       m_slave_id, next_slave_id;
    logic [NUM_SLAVES-1:0] s_ack, next_ack;

    logic [ID_W-1:0]       pick_id;
    logic                  pick_any;
    logic [SLV_W-1:0]      sel_word;
    logic                  req_g;

    av_rr_pick3 u_pick (
        .req    (S_M_req),
        .last   (last),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    always_comb begin
        sel_word = Slave0_out;
        case (pick_id)
            SLV1:    sel_word = Slave1_out;
            SLV2:    sel_word = Slave2_out;
            default: sel_word = Slave0_out;
        endcase
    end

    always_comb begin
        req_g = S_M_req[0];
        case (gnt)
            SLV1:    req_g = S_M_req[1];
            SLV2:    req_g = S_M_req[2];
            default: req_g = S_M_req[0];
        endcase
    end

`ifdef AV_ARB_ID_CHECK_EN
    logic [7:0] err_cnt, next_err_cnt;
    logic       id_mismatch;

    assign id_mismatch = (sel_word[ID_MSB:ID_LSB] != pick_id);
    assign Id_err_cnt  = err_cnt;
`else
    logic [ID_W-1:0] unused_id_bits;

    assign unused_id_bits = sel_word[ID_MSB:ID_LSB];
    assign Id_err_cnt     = '0;
`endif

    always_comb begin
        next_state    = state;
        next_last     = last;
        next_gnt      = gnt;
        next_valid    = m_valid;
        next_data     = m_data;
        next_slave_id = m_slave_id;
        next_ack      = s_ack;
`ifdef AV_ARB_ID_CHECK_EN
        next_err_cnt  = err_cnt;
`endif
        case (state)
            IDLE: begin
                next_valid = 1'b0;
                if (pick_any) begin
                    next_gnt = pick_id;
                    next_ack = slave_onehot(pick_id);
`ifdef AV_ARB_ID_CHECK_EN
                    // A mislabelled word is consumed from the slave but never shown to the master.
                    if (id_mismatch) begin
                        next_last  = pick_id;
                        next_state = DRAIN;
                        if (err_cnt != 8'hFF) next_err_cnt = err_cnt + 8'd1;
                    end else begin
                        next_data     = sel_word[DATA_W-1:0];
                        next_slave_id = pick_id;
                        next_valid    = 1'b1;
                        next_state    = PRESENT;
                    end
`else
                    next_data     = sel_word[DATA_W-1:0];
                    next_slave_id = pick_id;
                    next_valid    = 1'b1;
                    next_state    = PRESENT;
`endif
                end
            end
            PRESENT: begin
                if (!req_g) next_ack = '0;
                // Once the ack has already been released the slave may legally re-request,
                // so only a still-acked, still-requesting slave needs draining.
                if (M_ack) begin
                    next_valid = 1'b0;
                    next_last  = gnt;
                    if (!req_g || (s_ack == '0)) next_state = IDLE;
                    else                         next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!req_g) begin
                    next_ack   = '0;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_valid = 1'b0;
                next_ack   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock_pin or posedge Reset_pin) begin
        if (Reset_pin) begin
            state      <= IDLE;
            last       <= RR_RESET_LAST;
            gnt        <= SLV0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_slave_id <= SLV0;
            s_ack      <= '0;
        end else begin
            state      <= next_state;
            last       <= next_last;
            gnt        <= next_gnt;
            m_valid    <= next_valid;
            m_data     <= next_data;
            m_slave_id <= next_slave_id;
            s_ack      <= next_ack;
        end
    end

`ifdef AV_ARB_ID_CHECK_EN
    always_ff @(posedge Clock_pin or posedge Reset_pin) begin
        if (Reset_pin) err_cnt <= '0;
        else           err_cnt <= next_err_cnt;
    end
`endif

    assign S_ack      = s_ack;
    assign M_valid    = m_valid;
    assign M_data     = m_data;
    assign M_slave_id = m_slave_id;

endmodule

// File: tb/tb_av_slave_result_arbiter.sv
// Directed self-checking bench for av_slave_result_arbiter with hand-computed expectations.
module tb_av_slave_result_arbiter;

    logic        Clock_pin;
    logic        Reset_pin;
    logic [2:0]  S_M_req;
    logic [9:0]  Slave0_out;
    logic [9:0]  Slave1_out;
    logic [9:0]  Slave2_out;
    logic [2:0]  S_ack;
    logic        M_valid;
    logic [7:0]  M_data;
    logic [1:0]  M_slave_id;
    logic        M_ack;
    logic [7:0]  Id_err_cnt;

    int compared   = 0;
    int mismatched = 0;

    av_slave_result_arbiter dut (
        .Clock_pin  (Clock_pin),
        .Reset_pin  (Reset_pin),
        .S_M_req    (S_M_req),
        .Slave0_out (Slave0_out),
        .Slave1_out (Slave1_out),
        .Slave2_out (Slave2_out),
        .S_ack      (S_ack),
        .M_valid    (M_valid),
        .M_data     (M_data),
        .M_slave_id (M_slave_id),
        .M_ack      (M_ack),
        .Id_err_cnt (Id_err_cnt)
    );

    initial Clock_pin = 1'b0;
    always #5 Clock_pin = ~Clock_pin;

    // Hard stop in case a test sequence wedges.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] req, input logic mack);
        S_M_req = req;
        M_ack   = mack;
    endtask

    task automatic stepClock();
        @(posedge Clock_pin);
        #1;
    endtask

    task automatic pulseReset();
        Reset_pin = 1'b1;
        #2;
        Reset_pin = 1'b0;
    endtask

    logic [7:0] rr_data [3];
    int grants;
    int cyc;
    int onehot_viol;

    initial begin
        Reset_pin  = 1'b1;
        Slave0_out = '0;
        Slave1_out = '0;
        Slave2_out = '0;
        applyStimulus(3'b000, 1'b0);
        #2;
        checkOutput("rst_s_ack", S_ack, 3'b000);
        checkOutput("rst_m_valid", M_valid, 1'b0);
        checkOutput("rst_m_data", M_data, 8'h00);
        checkOutput("rst_m_id", M_slave_id, 2'd0);
        checkOutput("rst_err_cnt", Id_err_cnt, 8'h00);
        #10;
        Reset_pin = 1'b0;

        // Single request, master always ready, slave slow to drop by one cycle.
        Slave0_out = 10'h0A5;
        applyStimulus(3'b001, 1'b1);
        stepClock();
        checkOutput("single_valid", M_valid, 1'b1);
        checkOutput("single_data", M_data, 8'hA5);
        checkOutput("single_id", M_slave_id, 2'd0);
        checkOutput("single_ack", S_ack, 3'b001);
        stepClock();
        checkOutput("single_valid_1cyc", M_valid, 1'b0);
        checkOutput("single_ack_held", S_ack, 3'b001);
        applyStimulus(3'b000, 1'b1);
        stepClock();
        checkOutput("single_ack_drop", S_ack, 3'b000);
        checkOutput("single_data_hold", M_data, 8'hA5);

        // Round-robin with all slaves requesting continuously.
        pulseReset();
        Slave0_out = 10'h011;
        Slave1_out = 10'h122;
        Slave2_out = 10'h233;
        rr_data[0] = 8'h11;
        rr_data[1] = 8'h22;
        rr_data[2] = 8'h33;
        applyStimulus(3'b111, 1'b1);
        grants = 0;
        cyc = 0;
        onehot_viol = 0;
        while (grants < 6 && cyc < 40) begin
            stepClock();
            cyc++;
            if (M_valid) begin
                checkOutput($sformatf("rr%0d_id", grants), M_slave_id, grants % 3);
                checkOutput($sformatf("rr%0d_data", grants), M_data, rr_data[grants % 3]);
                grants++;
            end
            if ($countones(S_ack) > 1) onehot_viol++;
            for (int i = 0; i < 3; i++) S_M_req[i] = ~S_ack[i];
        end
        checkOutput("rr_grant_count", grants, 6);
        checkOutput("rr_cycles", cyc, 11);
        checkOutput("rr_ack_onehot", onehot_viol, 0);
        applyStimulus(3'b000, 1'b1);
        stepClock();
        stepClock();

        // Backpressure: slave 1 presented while master stalls, slave 2 arrives meanwhile.
        Slave1_out = 10'h13C;
        Slave2_out = 10'h2AB;
        applyStimulus(3'b010, 1'b0);
        stepClock();
        checkOutput("bp_valid", M_valid, 1'b1);
        checkOutput("bp_id", M_slave_id, 2'd1);
        checkOutput("bp_ack", S_ack, 3'b010);
        applyStimulus(3'b100, 1'b0);
        for (int k = 0; k < 5; k++) begin
            stepClock();
            checkOutput($sformatf("bp_hold%0d_valid", k), M_valid, 1'b1);
            checkOutput($sformatf("bp_hold%0d_data", k), M_data, 8'h3C);
            checkOutput($sformatf("bp_hold%0d_s2ack", k), S_ack[2], 1'b0);
        end
        applyStimulus(3'b100, 1'b1);
        stepClock();
        checkOutput("bp_release_valid", M_valid, 1'b0);
        stepClock();
        checkOutput("bp_next_valid", M_valid, 1'b1);
        checkOutput("bp_next_id", M_slave_id, 2'd2);
        checkOutput("bp_next_data", M_data, 8'hAB);
        applyStimulus(3'b000, 1'b1);
        stepClock();

        // Slow slave release: DRAIN blocks another pending requester.
        Slave0_out = 10'h05A;
        Slave1_out = 10'h177;
        applyStimulus(3'b001, 1'b1);
        stepClock();
        checkOutput("slow_valid", M_valid, 1'b1);
        checkOutput("slow_data", M_data, 8'h5A);
        applyStimulus(3'b011, 1'b1);
        for (int k = 0; k < 4; k++) begin
            stepClock();
            checkOutput($sformatf("slow_drain%0d_valid", k), M_valid, 1'b0);
            checkOutput($sformatf("slow_drain%0d_ack", k), S_ack, 3'b001);
        end
        applyStimulus(3'b010, 1'b1);
        stepClock();
        checkOutput("slow_ack_drop", S_ack, 3'b000);
        checkOutput("slow_no_grant", M_valid, 1'b0);
        stepClock();
        checkOutput("slow_next_id", M_slave_id, 2'd1);
        checkOutput("slow_next_data", M_data, 8'h77);
        checkOutput("slow_next_ack", S_ack, 3'b010);
        applyStimulus(3'b000, 1'b1);
        stepClock();

        // Reset while a result is presented.
        Slave2_out = 10'h2C3;
        applyStimulus(3'b100, 1'b0);
        stepClock();
        checkOutput("rmid_valid_pre", M_valid, 1'b1);
        checkOutput("rmid_id_pre", M_slave_id, 2'd2);
        #1;
        Reset_pin = 1'b1;
        #1;
        checkOutput("rmid_valid", M_valid, 1'b0);
        checkOutput("rmid_ack", S_ack, 3'b000);
        checkOutput("rmid_data", M_data, 8'h00);
        Reset_pin = 1'b0;
        Slave0_out = 10'h0D1;
        Slave1_out = 10'h1E2;
        applyStimulus(3'b011, 1'b1);
        stepClock();
        checkOutput("rmid_first_id", M_slave_id, 2'd0);
        checkOutput("rmid_first_data", M_data, 8'hD1);
        applyStimulus(3'b000, 1'b1);
        stepClock();
        stepClock();

`ifdef AV_ARB_ID_CHECK_EN
        pulseReset();
        Slave2_out = 10'h1FF;
        applyStimulus(3'b100, 1'b1);
        stepClock();
        checkOutput("idchk_ack", S_ack, 3'b100);
        checkOutput("idchk_valid", M_valid, 1'b0);
        checkOutput("idchk_cnt", Id_err_cnt, 8'd1);
        applyStimulus(3'b000, 1'b1);
        stepClock();
        checkOutput("idchk_ack_drop", S_ack, 3'b000);
`else
        checkOutput("err_cnt_tied", Id_err_cnt, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/av_slave_result_arbiter.md
# av_slave_result_arbiter

Collects computed results from the three slave cores and delivers them one at a time to the master core's result input. It replaces the free-running, id-select result mux with a 4-phase request/acknowledge arbiter. Slaves are granted in round-robin order, and each result is latched into a holding register. The result is then presented to the master with a valid/ack handshake, tagged with the originating slave id.

## Interface
- NUM_SLAVES, 3, number of slave result ports; fixed at 3, id width 2.
- DATA_W, 8, result payload width; slave words are DATA_W+2 bits with the id in the top 2 bits.
- Clock_pin  in  1  system clock; all state updates on the rising edge.
- Reset_pin  in  1  reset; asynchronous, active-high.
- S_M_req  in  3  per-slave result request, bit i = slave i; level, 4-phase.
- Slave0_out / Slave1_out / Slave2_out  in  10 each  slave result words, [9:8] = embedded id, [7:0] = data.
- S_ack  out  3  per-slave acknowledge, bit i = slave i; level, 4-phase.
- M_valid  out  1  result available to the master.
- M_data  out  8  latched result payload.
- M_slave_id  out  2  id of the slave that produced M_data.
- M_ack  in  1  master has consumed M_data; sampled only while M_valid=1.
- Id_err_cnt  out  8  saturating count of id-mismatch drops; constant 0 unless the ID-check macro is defined.

## Operation
- Slave contract:
  - Slave raises S_M_req[i] with Slave*_out stable.
  - Slave holds both until S_ack[i]=1, then drops S_M_req[i].
  - Slave must not re-raise S_M_req[i] while S_ack[i]=1.
- Round-robin pointer `last` (2 bits), reset 2, so slave 0 has first priority.
  - Priority order is last+1, last+2, last+3 (mod 3).
  - `last` updates to the granted id when the master acks.
- FSM states are IDLE, PRESENT and DRAIN.
- IDLE, when any S_M_req bit is 1:
  - Pick g by round-robin.
  - Capture data[g][7:0] into M_data and g into M_slave_id.
  - Set M_valid=1 and S_ack[g]=1, then go to PRESENT.
  - With no request, stay in IDLE; outputs hold their previous M_data and M_slave_id, M_valid=0.
- PRESENT:
  - M_data and M_slave_id are frozen.
  - On M_ack=1: clear M_valid and set last=g. Go to IDLE if S_M_req[g] is already 0, otherwise go to DRAIN.
- DRAIN: when S_M_req[g]=0, go to IDLE.
- S_ack[g] handling:
  - Set at capture.
  - Cleared on the first edge in PRESENT or DRAIN where S_M_req[g]=0.
  - Only one S_ack bit is ever 1 at a time.
- Requests from non-granted slaves wait; they are not lost.
- M_ack while M_valid=0 is ignored.

## Timing
- Reset values:
  - S_ack=0, M_valid=0, M_data=0, M_slave_id=0, Id_err_cnt=0.
  - State IDLE, last=2.
- Reset mid-operation aborts immediately: the held result is discarded and S_ack drops asynchronously.
- Latency: request seen at edge N puts M_valid and S_ack high after edge N.
- Minimum turnaround: IDLE, then PRESENT (1 cycle), then M_ack, then back in IDLE. This gives one result every 2 cycles when the slave drops its request promptly and M_ack is tied high.
- Simultaneous events:
  - M_ack=1 and S_M_req[g]=0 on the same edge: S_ack cleared, M_valid cleared, go directly to IDLE.
  - All three requests pending: granted in order last+1, last+2, last+3. No slave waits more than 2 other grants.
  - M_ack held permanently high: each result is still valid for exactly 1 cycle.

## Configuration
- `AV_ARB_ID_CHECK_EN` defined:
  - At capture in IDLE, compare data[g][9:8] against g.
  - On mismatch, still assert S_ack[g] so the slave is consumed, but leave M_valid at 0.
  - Increment Id_err_cnt, saturating at 255.
  - Go to DRAIN, or to IDLE if the request has already dropped. `last` advances to g.
- Not defined: embedded id bits are ignored, Id_err_cnt is tied to 0, and no checking logic is present.

## Structure
- Shared package avrisc621_mc_pkg holds:
  - slave id constants SLV0=2'd0, SLV1=2'd1, SLV2=2'd2;
  - DATA_W=8 and the id field position [9:8];
  - the FSM state encoding (IDLE, PRESENT, DRAIN).
- One sub-module, av_rr_pick3: a combinational 3-way round-robin picker.
  - Inputs: req[2:0], last[1:0].
  - Outputs: gnt_id[1:0], any.
- The top block holds the FSM, holding registers, ack generation and the optional checker.

## Test plan
- Single request:
  - Stimulus: after reset, S_M_req=3'b001, Slave0_out=10'h0A5, M_ack tied 1.
  - Response: M_valid=1 for 1 cycle with M_data=8'hA5 and M_slave_id=0; S_ack[0]=1 until the request drops.
- Round-robin:
  - Stimulus: S_M_req=3'b111 held, each slave re-requesting after its ack drops.
  - Response: grant order 0,1,2,0,1,2, with M_data matching the respective slave words.
- Master backpressure:
  - Stimulus: slave 1 request with data 8'h3C, M_ack=0 for 5 cycles.
  - Response: M_valid and M_data=8'h3C stable for all 5 cycles; slave 2 request arriving meanwhile is not granted until after M_ack.
- Slow slave release:
  - Stimulus: M_ack=1, slave keeps S_M_req high 4 cycles after ack.
  - Response: FSM in DRAIN, no new grant until the request drops; S_ack falls on the edge after the drop.
- Reset mid-PRESENT:
  - Stimulus: assert Reset_pin while M_valid=1.
  - Response: M_valid, S_ack and M_data go to 0 immediately; first grant after release is slave 0.
- With `AV_ARB_ID_CHECK_EN`:
  - Stimulus: Slave2_out=10'h1FF (id 1 on port 2).
  - Response: S_ack[2] asserted, M_valid stays 0, Id_err_cnt becomes 1.
